// File: rtl/enemy_motion_pkg.sv
// Shared constants and encodings for the enemy motion block and its helpers.
package enemy_motion_pkg;

    // Sprite box size; hit bounds are inclusive, so the box spans WIDTH+1 pixels.
    localparam logic [10:0] ENEMY_WIDTH   = 11'd64;
    localparam logic [9:0]  ENEMY_HEIGHT  = 10'd64;
    localparam logic [10:0] SCREEN_WIDTH  = 11'd1280;
    localparam logic [9:0]  SCREEN_HEIGHT = 10'd720;

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_DYING = 2'd1,
        ST_DEAD  = 2'd2
    } state_e;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    // Last counter value of a phase lasting 'frames' ticks; zero is treated as one.
    function automatic logic [7:0] last_frame(input logic [7:0] frames);
        return (frames == 8'd0) ? 8'd0 : frames - 8'd1;
    endfunction

endpackage

// File: rtl/enemy_hit_test.sv
// Combinational box-contains-point test with inclusive bounds.
// Widened sums keep the upper bounds from wrapping near the screen edge.
module enemy_hit_test
    import enemy_motion_pkg::*;
#(
    parameter logic [10:0] BOX_W = ENEMY_WIDTH,
    parameter logic [9:0]  BOX_H = ENEMY_HEIGHT
) (
    input  logic        pt_valid,
    input  logic [10:0] box_x,
    input  logic [9:0]  box_y,
    input  logic [10:0] pt_x,
    input  logic [9:0]  pt_y,
    output logic        hit
);

    logic [11:0] x_hi;
    logic [10:0] y_hi;
    logic        in_x;
    logic        in_y;

    assign x_hi = {1'b0, box_x} + {1'b0, BOX_W};
    assign y_hi = {1'b0, box_y} + {1'b0, BOX_H};
    assign in_x = (pt_x >= box_x) && ({1'b0, pt_x} <= x_hi);
    assign in_y = (pt_y >= box_y) && ({1'b0, pt_y} <= y_hi);
    assign hit  = pt_valid && in_x && in_y;

endmodule

// File: rtl/enemy_motion.sv
// Per-enemy movement and life-cycle controller feeding the sprite draw stage.
// Position only moves on frame ticks so the drawn sprite never tears.
module enemy_motion
    import enemy_motion_pkg::*;
#(
    parameter logic [10:0] X_START        = 11'd100,
    parameter logic [9:0]  Y_START        = 10'd50,
    parameter logic [10:0] X_MIN          = 11'd0,
    parameter logic [10:0] X_MAX          = 11'd1216,
    parameter logic [9:0]  Y_LIMIT        = 10'd700,
    parameter logic [10:0] DX             = 11'd4,
    parameter logic [9:0]  DY             = 10'd16,
    parameter logic [7:0]  DYING_FRAMES   = 8'd16,
    parameter logic [7:0]  RESPAWN_FRAMES = 8'd60
) (
    input  logic        pixclk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        bullet_valid,
    input  logic [10:0] bullet_x,
    input  logic [9:0]  bullet_y,
    output logic [10:0] enemy_pos_x,
    output logic [9:0]  enemy_pos_y,
    output logic        killed,
    output logic        hit_ack,
    output logic        breach
);

    state_e      state_q, state_d;
    dir_e        dir_q, dir_d;
    logic [10:0] pos_x_q, pos_x_d;
    logic [9:0]  pos_y_q, pos_y_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        killed_q, killed_d;
    logic        hit_ack_q, hit_ack_d;
    logic        breach_q, breach_d;

    logic        hit;
    logic        do_drop;
    logic [11:0] x_right_sum;
    logic [11:0] x_left_thresh;
    logic [10:0] y_drop_sum;

    enemy_hit_test #(
        .BOX_W (ENEMY_WIDTH),
        .BOX_H (ENEMY_HEIGHT)
    ) u_hit_test (
        .pt_valid (bullet_valid),
        .box_x    (pos_x_q),
        .box_y    (pos_y_q),
        .pt_x     (bullet_x),
        .pt_y     (bullet_y),
        .hit      (hit)
    );

    assign x_right_sum   = {1'b0, pos_x_q} + {1'b0, DX};
    assign x_left_thresh = {1'b0, X_MIN} + {1'b0, DX};
    assign y_drop_sum    = {1'b0, pos_y_q} + {1'b0, DY};

    // Next-state: hit beats movement; bounces drop a row and may breach.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        cnt_d     = cnt_q;
        hit_ack_d = 1'b0;
        breach_d  = 1'b0;
        do_drop   = 1'b0;

        case (state_q)
            ST_ALIVE: begin
                if (hit) begin
                    state_d   = ST_DYING;
                    cnt_d     = 8'd0;
                    hit_ack_d = 1'b1;
                end else if (frame_tick) begin
                    if (dir_q == DIR_RIGHT) begin
                        if (x_right_sum >= {1'b0, X_MAX}) begin
                            pos_x_d = X_MAX;
                            dir_d   = DIR_LEFT;
                            do_drop = 1'b1;
                        end else begin
                            pos_x_d = x_right_sum[10:0];
                        end
                    end else begin
                        if ({1'b0, pos_x_q} <= x_left_thresh) begin
                            pos_x_d = X_MIN;
                            dir_d   = DIR_RIGHT;
                            do_drop = 1'b1;
                        end else begin
                            pos_x_d = pos_x_q - DX;
                        end
                    end
                    if (do_drop) begin
                        if (y_drop_sum > {1'b0, Y_LIMIT}) begin
                            breach_d = 1'b1;
                            pos_x_d  = X_START;
                            pos_y_d  = Y_START;
                            dir_d    = DIR_RIGHT;
                        end else begin
                            pos_y_d = y_drop_sum[9:0];
                        end
                    end
                end
            end
            ST_DYING: begin
                if (frame_tick) begin
                    if (cnt_q >= last_frame(DYING_FRAMES)) begin
                        state_d = ST_DEAD;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_DEAD: begin
                if (frame_tick) begin
                    if (cnt_q >= last_frame(RESPAWN_FRAMES)) begin
                        state_d = ST_ALIVE;
                        cnt_d   = 8'd0;
                        pos_x_d = X_START;
                        pos_y_d = Y_START;
                        dir_d   = DIR_RIGHT;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_ALIVE;
                cnt_d   = 8'd0;
            end
        endcase

        killed_d = (state_d != ST_ALIVE);
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            state_q   <= ST_ALIVE;
            dir_q     <= DIR_RIGHT;
            pos_x_q   <= X_START;
            pos_y_q   <= Y_START;
            cnt_q     <= 8'd0;
            killed_q  <= 1'b0;
            hit_ack_q <= 1'b0;
            breach_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            cnt_q     <= cnt_d;
            killed_q  <= killed_d;
            hit_ack_q <= hit_ack_d;
            breach_q  <= breach_d;
        end
    end

    assign enemy_pos_x = pos_x_q;
    assign enemy_pos_y = pos_y_q;
    assign killed      = killed_q;
    assign hit_ack     = hit_ack_q;
    assign breach      = breach_q;

endmodule

// File: doc/enemy_motion.md
Name: enemy_motion

Overview:
Per-enemy movement and life-cycle controller. Sits directly upstream of the enemy sprite draw stage and drives its position and killed inputs. Updates position once per frame, so the drawn sprite never tears mid-frame. Detects bullet hits and sequences the enemy through dying, dead and respawn.

Parameters:
X_START, 11'd100, respawn / reset x position (top-left of sprite box)
Y_START, 10'd50, respawn / reset y position
X_MIN, 11'd0, left bounce limit for enemy_pos_x
X_MAX, 11'd1216, right bounce limit for enemy_pos_x (screen width minus ENEMY_WIDTH)
Y_LIMIT, 10'd700, lowest allowed enemy_pos_y; crossing it is a breach
DX, 11'd4, horizontal step per frame
DY, 10'd16, vertical drop per bounce
DYING_FRAMES, 8'd16, frames spent in DYING
RESPAWN_FRAMES, 8'd60, frames spent in DEAD before respawn

Ports:
pixclk  input  1  pixel clock; all logic on posedge
rst_n  input  1  synchronous active-low reset
frame_tick  input  1  one-cycle pulse at start of vertical blank
bullet_valid  input  1  a player bullet is live this cycle
bullet_x  input  11  bullet tip x
bullet_y  input  10  bullet tip y
enemy_pos_x  output  11  registered sprite x, to draw stage
enemy_pos_y  output  10  registered sprite y, to draw stage
killed  output  1  high in DYING and DEAD
hit_ack  output  1  one-cycle pulse: bullet consumed, bullet owner must retire it
breach  output  1  one-cycle pulse: enemy passed Y_LIMIT

Behaviour:
- Reset (rst_n=0 at posedge): pos=(X_START,Y_START), dir=right, state=ALIVE, killed=0, hit_ack=0, breach=0, frame counter=0. A reset mid-DYING or mid-DEAD returns directly to ALIVE at the start position.
- States: ALIVE, DYING, DEAD. killed is registered: 1 iff state is DYING or DEAD.
- Hit test in ALIVE, every cycle: hit = bullet_valid && bullet_x in [pos_x, pos_x+ENEMY_WIDTH] && bullet_y in [pos_y, pos_y+ENEMY_HEIGHT]. Bounds are inclusive, matching the draw stage. Use 12/11-bit sums; no wrap.
- On hit at edge n: state becomes DYING, killed=1, hit_ack=1 for exactly one cycle, counter cleared. Position is frozen.
- Hits are ignored outside ALIVE; hit_ack stays 0.
- Movement occurs in ALIVE only, on the edge after frame_tick.
  - Right: nx = pos_x+DX. If nx >= X_MAX: pos_x=X_MAX, dir=left, drop.
  - Left: if pos_x <= X_MIN+DX: pos_x=X_MIN, dir=right, drop.
  - Otherwise pos_x=nx.
  - drop: ny = pos_y+DY. If ny > Y_LIMIT: breach pulse, pos to start, dir=right, stay ALIVE. Else pos_y=ny.
- Simultaneous frame_tick and hit: hit wins and there is no movement that frame.
- DYING: counter increments on each frame_tick. At DYING_FRAMES-1 plus a tick: state=DEAD, counter=0.
- DEAD: counter increments on each frame_tick. At RESPAWN_FRAMES-1 plus a tick: state=ALIVE, pos=(X_START,Y_START), dir=right, killed=0.
- DYING_FRAMES=0 or RESPAWN_FRAMES=0 is treated as 1.
- Outputs change only on pixclk edges. Position changes only on frame_tick edges, hit freezes and reset.

Decomposition:
- Shared constants file holds ENEMY_WIDTH, ENEMY_HEIGHT, screen width/height and the state encodings (ALIVE=2'd0, DYING=2'd1, DEAD=2'd2).
- One natural sub-module: enemy_hit_test, a combinational box-contains-point check reusable for the player/bullet. Registering stays in enemy_motion.

Test Plan:
- Reset then 3 frame_ticks -> pos_x 100,104,108 with pos_y=50 and killed=0; breach/hit_ack never asserted.
- Start pos_x=1214, dir right, tick -> pos_x=1216, pos_y=66, dir left; next tick -> pos_x=1212.
- Bullet (120,60) valid one cycle with enemy at (100,50) -> next edge killed=1, hit_ack=1 for one cycle. Bullet (164,114) hits (inclusive corner); (165,50) misses.
- Hit and frame_tick in same cycle -> position unchanged and killed=1. A second bullet in DYING gives no hit_ack.
- After hit: 16 ticks -> DEAD (killed still 1); 60 more ticks -> killed=0 at (100,50), dir right.
- pos_y=690, right-edge bounce -> breach pulse 1 cycle, pos=(100,50). Reset asserted mid-DEAD -> ALIVE at (100,50) next edge.
